// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester, peripheral and status signals of the CPU/DMA bus arbiter.
interface bus_arbiter_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 8
);
    logic                 cpu_req, cpu_we, cpu_ack;
    logic                 dma_req, dma_we, dma_ack;
    logic [ADDR_SIZE-1:0] cpu_addr, dma_addr, bus_addr;
    logic [DATA_SIZE-1:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata;
    logic [DATA_SIZE-1:0] bus_wdata, bus_rdata;
    logic                 bus_sel, bus_we, bus_ready;
    logic                 owner, err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  bus_rdata, bus_ready,
        output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        output bus_sel, bus_we, bus_addr, bus_wdata, owner, err
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output bus_rdata, bus_ready,
        input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
        input  bus_sel, bus_we, bus_addr, bus_wdata, owner, err
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/DMA arbiter driving one bus transaction at a time with wait states.
// Define BUS_ARB_TIMEOUT_EN to abort accesses stalled for TIMEOUT cycles (err pulse, read data all ones).
module bus_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 16
) (
    input logic         clk,
    input logic         rst_n,
    bus_arbiter_if.slave sys
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [7:0] dma_run;
    logic       dma_win;
    logic       expire;

    // DMA has priority unless the CPU has waited through a full burst
    assign dma_win = sys.dma_req && !(sys.cpu_req && dma_run == 8'(BURST_MAX));

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign expire = !sys.bus_ready && wait_cnt == 8'(TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state != ACCESS)
            wait_cnt <= '0;
        else if (!sys.bus_ready)
            wait_cnt <= wait_cnt + 8'd1;
    end
`else
    logic unused_timeout;

    assign expire = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dma_run       <= '0;
            sys.cpu_ack   <= 1'b0;
            sys.dma_ack   <= 1'b0;
            sys.cpu_rdata <= '0;
            sys.dma_rdata <= '0;
            sys.bus_sel   <= 1'b0;
            sys.bus_we    <= 1'b0;
            sys.bus_addr  <= '0;
            sys.bus_wdata <= '0;
            sys.owner     <= 1'b0;
            sys.err       <= 1'b0;
        end else begin
            sys.cpu_ack <= 1'b0;
            sys.dma_ack <= 1'b0;
            sys.err     <= 1'b0;
            case (state)
                IDLE: begin
                    dma_run <= dma_win ? (dma_run == 8'hFF ? dma_run : dma_run + 8'd1) : '0;
                    if (sys.cpu_req || sys.dma_req) begin
                        state         <= ACCESS;
                        sys.owner     <= dma_win;
                        sys.bus_sel   <= 1'b1;
                        sys.bus_we    <= dma_win ? sys.dma_we : sys.cpu_we;
                        sys.bus_addr  <= dma_win ? sys.dma_addr : sys.cpu_addr;
                        sys.bus_wdata <= dma_win ? sys.dma_wdata : sys.cpu_wdata;
                    end
                end
                ACCESS: begin
                    if (sys.bus_ready || expire) begin
                        state       <= DONE;
                        sys.bus_sel <= 1'b0;
                        sys.bus_we  <= 1'b0;
                        sys.cpu_ack <= !sys.owner;
                        sys.dma_ack <= sys.owner;
                        sys.err     <= expire;
                        if (!sys.bus_we && sys.owner)
                            sys.dma_rdata <= expire ? '1 : sys.bus_rdata;
                        if (!sys.bus_we && !sys.owner)
                            sys.cpu_rdata <= expire ? '1 : sys.bus_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
